// File: rtl/cp0_ctrl.sv
// cp0_ctrl: CP0 system-control register block for the MIPS core.
// Provides sel-indexed MTC0/MFC0 access to BadVAddr, Count, Compare, Status,
// Cause, EPC, PrId, EBase and Config. It also provides a prescaled Count
// timer, exception/ERET commit handling, a masked interrupt request and the
// exception entry vector.
// Optional feature macro: CP0_CAUSE_IV_EN. It makes Cause.IV writable and
// enables the special interrupt vector (offset 0x200 / BFC0_0400).
module cp0_ctrl #(
  parameter int          COUNT_DIV    = 2,
  parameter int          HW_INT_NUM   = 6,
  parameter logic [31:0] EBASE_RESET  = 32'hBFC0_0000,
  parameter logic [31:0] PRID_VALUE   = 32'h0000_4220,
  parameter logic [31:0] CONFIG_VALUE = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wen_i,
  input  logic [4:0]            waddr_i,
  input  logic [2:0]            wsel_i,
  input  logic [4:0]            raddr_i,
  input  logic [2:0]            rsel_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           data_o,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic                  eret_i,
  input  logic [31:0]           exc_pc_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  exc_bv_i,
  input  logic                  bd_i,
  input  logic [HW_INT_NUM-1:0] int_i,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic [31:0]           exc_vector_o,
  output logic                  int_req_o,
  output logic                  timer_int_o
);

  localparam int PRESC_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(COUNT_DIV - 1);

  // {reg, sel} addresses of the mapped registers
  localparam logic [7:0] A_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] A_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] A_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] A_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] A_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC      = {5'd14, 3'd0};
  localparam logic [7:0] A_PRID     = {5'd15, 3'd0};
  localparam logic [7:0] A_EBASE    = {5'd15, 3'd1};
  localparam logic [7:0] A_CONFIG   = {5'd16, 3'd0};

  // BEV comes out of reset set and software cannot clear it
  localparam logic STATUS_BEV = 1'b1;

  logic [31:0]        badvaddr_reg;
  logic [31:0]        count_reg;
  logic [31:0]        compare_reg;
  logic [PRESC_W-1:0] presc_reg;
  logic               timer_int_reg;
  logic [7:0]         status_im_reg;
  logic               status_exl_reg;
  logic               status_ie_reg;
  logic               cause_bd_reg;
  logic               cause_ti_reg;
  logic [5:0]         cause_ip_hw_reg;   // IP[7:2]
  logic [1:0]         cause_ip_sw_reg;   // IP[1:0]
  logic [4:0]         cause_exc_code_reg;
  logic [31:0]        epc_reg;
  logic [17:0]        ebase_hi_reg;      // EBase[29:12]

  logic               cause_iv;
  logic [5:0]         ip_hw_next;
  logic [7:0]         cause_ip;
  logic [31:0]        ebase;
  logic [7:0]         waddr_sel;

  // An exception in the same cycle throws away any MTC0 and any ERET
  logic mtc0_en;
  logic eret_en;
  logic wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_ebase;

  assign mtc0_en    = wen_i & ~exc_valid_i;
  assign eret_en    = eret_i & ~exc_valid_i;
  assign waddr_sel  = {waddr_i, wsel_i};
  assign wr_count   = mtc0_en && (waddr_sel == A_COUNT);
  assign wr_compare = mtc0_en && (waddr_sel == A_COMPARE);
  assign wr_status  = mtc0_en && (waddr_sel == A_STATUS);
  assign wr_cause   = mtc0_en && (waddr_sel == A_CAUSE);
  assign wr_epc     = mtc0_en && (waddr_sel == A_EPC);
  assign wr_ebase   = mtc0_en && (waddr_sel == A_EBASE);

  // Hardware lines land on IP[2 +: HW_INT_NUM]; the remaining IP[7:2] bits read 0
  for (genvar gi = 0; gi < 6; gi++) begin : g_ip_hw
    if (gi < HW_INT_NUM) begin : g_used
      assign ip_hw_next[gi] = int_i[gi];
    end else begin : g_unused
      assign ip_hw_next[gi] = 1'b0;
    end
  end

`ifdef CP0_CAUSE_IV_EN
  logic cause_iv_reg;

  // Cause.IV is a plain software-writable bit
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cause_iv_reg <= 1'b0;
    end else if (wr_cause) begin
      cause_iv_reg <= data_i[23];
    end
  end

  assign cause_iv = cause_iv_reg;
`else
  assign cause_iv = 1'b0;
`endif

  // Count with prescaler; a software write reloads Count and restarts the prescaler
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_reg <= '0;
      presc_reg <= '0;
    end else if (wr_count) begin
      count_reg <= data_i;
      presc_reg <= '0;
    end else if (presc_reg == PRESC_MAX) begin
      count_reg <= count_reg + 32'd1;
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // Compare register and timer interrupt; a Compare write acknowledges the timer
  always_ff @(posedge clk) begin
    if (!resetn) begin
      compare_reg   <= '0;
      timer_int_reg <= 1'b0;
      cause_ti_reg  <= 1'b0;
    end else begin
      cause_ti_reg <= timer_int_reg;
      if (wr_compare) begin
        compare_reg   <= data_i;
        timer_int_reg <= 1'b0;
      end else if ((count_reg == compare_reg) && (compare_reg != 32'd0)) begin
        timer_int_reg <= 1'b1;
      end
    end
  end

  // Status: exception sets EXL, ERET clears it and overrides an MTC0 to EXL
  always_ff @(posedge clk) begin
    if (!resetn) begin
      status_im_reg  <= '0;
      status_exl_reg <= 1'b0;
      status_ie_reg  <= 1'b0;
    end else if (exc_valid_i) begin
      status_exl_reg <= 1'b1;
    end else begin
      if (wr_status) begin
        status_im_reg  <= data_i[15:8];
        status_exl_reg <= data_i[1];
        status_ie_reg  <= data_i[0];
      end
      if (eret_en) begin
        status_exl_reg <= 1'b0;
      end
    end
  end

  // Exception recording (EPC/BD only on first-level entry) and software writes
  always_ff @(posedge clk) begin
    if (!resetn) begin
      badvaddr_reg       <= '0;
      epc_reg            <= '0;
      cause_bd_reg       <= 1'b0;
      cause_exc_code_reg <= '0;
      cause_ip_sw_reg    <= '0;
      ebase_hi_reg       <= EBASE_RESET[29:12];
    end else if (exc_valid_i) begin
      cause_exc_code_reg <= exc_code_i;
      if (!status_exl_reg) begin
        epc_reg      <= bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
        cause_bd_reg <= bd_i;
      end
      if (exc_bv_i) begin
        badvaddr_reg <= exc_badvaddr_i;
      end
    end else begin
      if (wr_epc) begin
        epc_reg <= data_i;
      end
      if (wr_cause) begin
        cause_ip_sw_reg <= data_i[9:8];
      end
      if (wr_ebase) begin
        ebase_hi_reg <= data_i[29:12];
      end
    end
  end

  // Hardware interrupt lines are sampled into Cause.IP every cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cause_ip_hw_reg <= '0;
    end else begin
      cause_ip_hw_reg <= ip_hw_next;
    end
  end

  assign cause_ip = {cause_ip_hw_reg[5] | cause_ti_reg, cause_ip_hw_reg[4:0], cause_ip_sw_reg};
  assign ebase    = {EBASE_RESET[31:30], ebase_hi_reg, EBASE_RESET[11:0]};

  assign status_o = {9'b0, STATUS_BEV, 6'b0, status_im_reg, 6'b0, status_exl_reg, status_ie_reg};
  assign cause_o  = {cause_bd_reg, cause_ti_reg, 6'b0, cause_iv, 7'b0, cause_ip, 1'b0,
                     cause_exc_code_reg, 2'b0};
  assign epc_o       = epc_reg;
  assign timer_int_o = timer_int_reg;
  assign int_req_o   = status_ie_reg & ~status_exl_reg & (|(cause_ip & status_im_reg));

  // Exception entry address; IV selects the dedicated interrupt vector for ExcCode 0
  always_comb begin
    exc_vector_o = STATUS_BEV ? 32'hBFC0_0380 : {ebase[31:12], 12'h180};
    if (cause_iv && (cause_exc_code_reg == 5'd0)) begin
      exc_vector_o = STATUS_BEV ? 32'hBFC0_0400 : {ebase[31:12], 12'h200};
    end
  end

  // MFC0 read mux; unmapped addresses and the reset period read as zero
  always_comb begin
    data_o = '0;
    if (resetn) begin
      case ({raddr_i, rsel_i})
        A_BADVADDR: data_o = badvaddr_reg;
        A_COUNT:    data_o = count_reg;
        A_COMPARE:  data_o = compare_reg;
        A_STATUS:   data_o = status_o;
        A_CAUSE:    data_o = cause_o;
        A_EPC:      data_o = epc_reg;
        A_PRID:     data_o = PRID_VALUE;
        A_EBASE:    data_o = ebase;
        A_CONFIG:   data_o = CONFIG_VALUE;
        default:    data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl (COUNT_DIV=2, HW_INT_NUM=2). Expected values are
// queued when stimulus is applied and checked in order as outputs are observed.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wen_i;
  logic [4:0]  waddr_i;
  logic [2:0]  wsel_i;
  logic [4:0]  raddr_i;
  logic [2:0]  rsel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic        eret_i;
  logic [31:0] exc_pc_i;
  logic [31:0] exc_badvaddr_i;
  logic        exc_bv_i;
  logic        bd_i;
  logic [1:0]  int_i;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] exc_vector_o;
  logic        int_req_o;
  logic        timer_int_o;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_entry_t;

  sb_entry_t sb[$];
  int checks = 0;
  int passed = 0;

  cp0_ctrl #(
    .COUNT_DIV (2),
    .HW_INT_NUM(2)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .wen_i         (wen_i),
    .waddr_i       (waddr_i),
    .wsel_i        (wsel_i),
    .raddr_i       (raddr_i),
    .rsel_i        (rsel_i),
    .data_i        (data_i),
    .data_o        (data_o),
    .exc_valid_i   (exc_valid_i),
    .exc_code_i    (exc_code_i),
    .eret_i        (eret_i),
    .exc_pc_i      (exc_pc_i),
    .exc_badvaddr_i(exc_badvaddr_i),
    .exc_bv_i      (exc_bv_i),
    .bd_i          (bd_i),
    .int_i         (int_i),
    .status_o      (status_o),
    .cause_o       (cause_o),
    .epc_o         (epc_o),
    .exc_vector_o  (exc_vector_o),
    .int_req_o     (int_req_o),
    .timer_int_o   (timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic sb_push(input string tag, input logic [31:0] val);
    sb_entry_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_entry_t e;
    checks++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %h expected nothing", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) begin
        passed++;
        $display("check %-14s observed %h expected %h", e.tag, obs, e.val);
      end else begin
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [2:0] s);
    raddr_i = a;
    rsel_i  = s;
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    wen_i   = 1'b1;
    waddr_i = a;
    wsel_i  = s;
    data_i  = d;
    step();
    wen_i   = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                     input logic bv, input logic [31:0] bva);
    exc_valid_i    = 1'b1;
    exc_code_i     = code;
    exc_pc_i       = pc;
    bd_i           = bd;
    exc_bv_i       = bv;
    exc_badvaddr_i = bva;
    step();
    exc_valid_i    = 1'b0;
    exc_bv_i       = 1'b0;
    bd_i           = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; wen_i = 1'b0; waddr_i = '0; wsel_i = '0; raddr_i = '0; rsel_i = '0;
    data_i = '0; exc_valid_i = 1'b0; exc_code_i = '0; eret_i = 1'b0; exc_pc_i = '0;
    exc_badvaddr_i = '0; exc_bv_i = 1'b0; bd_i = 1'b0; int_i = '0;

    // Reset state
    step(); step();
    sb_push("rst_status", 32'h0040_0000); sb_check(status_o);
    sb_push("rst_cause",  32'h0);         sb_check(cause_o);
    sb_push("rst_epc",    32'h0);         sb_check(epc_o);
    sb_push("rst_vector", 32'hBFC0_0380); sb_check(exc_vector_o);
    sb_push("rst_timer",  32'h0);         sb_check({31'b0, timer_int_o});
    rd(5'd12, 3'd0);
    sb_push("rst_data_o", 32'h0);         sb_check(data_o);
    resetn = 1'b1;

    // Compare=0 must never raise the timer even though Count==Compare
    step(); step();
    sb_push("cmp0_no_timer", 32'h0);      sb_check({31'b0, timer_int_o});

    // 1. Count wrap with prescaler of 2
    mtc0(5'd9, 3'd0, 32'hFFFF_FFFE);
    rd(5'd9, 3'd0);
    sb_push("cnt_load", 32'hFFFF_FFFE); sb_check(data_o);
    sb_push("cnt_s1",   32'hFFFF_FFFE); step(); sb_check(data_o);
    sb_push("cnt_s2",   32'hFFFF_FFFF); step(); sb_check(data_o);
    sb_push("cnt_s3",   32'hFFFF_FFFF); step(); sb_check(data_o);
    sb_push("cnt_wrap", 32'h0000_0000); step(); sb_check(data_o);

    // 2. Timer interrupt
    mtc0(5'd12, 3'd0, 32'h0000_8001);
    mtc0(5'd11, 3'd0, 32'd5);
    mtc0(5'd9,  3'd0, 32'd3);
    step(); step(); step(); step();
    sb_push("tmr_before", 32'h0);         sb_check({31'b0, timer_int_o});
    step();
    sb_push("tmr_set",    32'h1);         sb_check({31'b0, timer_int_o});
    sb_push("ti_lag",     32'h0);         sb_check({31'b0, cause_o[30]});
    step();
    sb_push("cause_ti",   32'h4000_8000); sb_check(cause_o);
    sb_push("int_req_ti", 32'h1);         sb_check({31'b0, int_req_o});
    mtc0(5'd11, 3'd0, 32'h100);
    sb_push("tmr_clr",    32'h0);         sb_check({31'b0, timer_int_o});
    step();
    sb_push("ti_clr",     32'h0);         sb_check(cause_o);
    sb_push("int_req_clr", 32'h0);        sb_check({31'b0, int_req_o});

    // 3. Exception in delay slot with bad address, then nested exception
    exc(5'd4, 32'hBFC0_0104, 1'b1, 1'b1, 32'h8000_0003);
    sb_push("exc_epc",    32'hBFC0_0100); sb_check(epc_o);
    sb_push("exc_cause",  32'h8000_0010); sb_check(cause_o);
    sb_push("exc_status", 32'h0040_8003); sb_check(status_o);
    sb_push("exc_vector", 32'hBFC0_0380); sb_check(exc_vector_o);
    rd(5'd8, 3'd0);
    sb_push("badvaddr",   32'h8000_0003); sb_check(data_o);
    exc(5'd5, 32'h0000_2000, 1'b0, 1'b0, 32'h0);
    sb_push("exc2_epc",   32'hBFC0_0100); sb_check(epc_o);
    sb_push("exc2_cause", 32'h8000_0014); sb_check(cause_o);
    rd(5'd8, 3'd0);
    sb_push("exc2_bva",   32'h8000_0003); sb_check(data_o);

    // ERET clears EXL
    eret_i = 1'b1; step(); eret_i = 1'b0;
    sb_push("eret_status", 32'h0040_8001); sb_check(status_o);

    // 4. Exception + ERET + MTC0 EPC in one cycle: exception wins
    eret_i  = 1'b1;
    wen_i   = 1'b1; waddr_i = 5'd14; wsel_i = 3'd0; data_i = 32'h1234;
    exc(5'd12, 32'h8000_0200, 1'b0, 1'b0, 32'h0);
    eret_i  = 1'b0; wen_i = 1'b0;
    sb_push("clash_epc",    32'h8000_0200); sb_check(epc_o);
    sb_push("clash_status", 32'h0040_8003); sb_check(status_o);
    sb_push("clash_cause",  32'h0000_0030); sb_check(cause_o);

    // ERET with an MTC0 to Status: IM/IE applied, EXL forced clear
    eret_i = 1'b1;
    mtc0(5'd12, 3'd0, 32'h0000_0403);
    eret_i = 1'b0;
    sb_push("eret_mtc0", 32'h0040_0401); sb_check(status_o);

    // 5. EBase masking, read-only BEV, constants and unmapped reads
    mtc0(5'd15, 3'd1, 32'h8000_1FFF);
    rd(5'd15, 3'd1);
    sb_push("ebase",      32'h8000_1000); sb_check(data_o);
    mtc0(5'd12, 3'd0, 32'h0000_0000);
    rd(5'd12, 3'd0);
    sb_push("bev_ro",     32'h0040_0000); sb_check(data_o);
    sb_push("bev_vector", 32'hBFC0_0380); sb_check(exc_vector_o);
    rd(5'd15, 3'd0);
    sb_push("prid",       32'h0000_4220); sb_check(data_o);
    rd(5'd3, 3'd0);
    sb_push("unmapped",   32'h0);         sb_check(data_o);
    rd(5'd16, 3'd0);
    sb_push("config",     32'h8000_0000); sb_check(data_o);
    mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
`ifdef CP0_CAUSE_IV_EN
    sb_push("cause_wmask", 32'h0080_0330);
`else
    sb_push("cause_wmask", 32'h0000_0330);
`endif
    sb_check(cause_o);

    // 6. Hardware interrupt line 1 -> IP[3]
    int_i = 2'b10;
    mtc0(5'd12, 3'd0, 32'h0000_0801);
`ifdef CP0_CAUSE_IV_EN
    sb_push("hw_ip3", 32'h0080_0B30);
`else
    sb_push("hw_ip3", 32'h0000_0B30);
`endif
    sb_check(cause_o);
    sb_push("hw_int_req", 32'h1);         sb_check({31'b0, int_req_o});
    mtc0(5'd12, 3'd0, 32'h0000_0803);
    sb_push("exl_masks",  32'h0);         sb_check({31'b0, int_req_o});

    // Mid-run reset
    resetn = 1'b0;
    step();
    rd(5'd12, 3'd0);
    sb_push("rr_status", 32'h0040_0000); sb_check(status_o);
    sb_push("rr_cause",  32'h0);         sb_check(cause_o);
    sb_push("rr_epc",    32'h0);         sb_check(epc_o);
    sb_push("rr_intreq", 32'h0);         sb_check({31'b0, int_req_o});
    sb_push("rr_timer",  32'h0);         sb_check({31'b0, timer_int_o});
    sb_push("rr_data_o", 32'h0);         sb_check(data_o);
    resetn = 1'b1;
    int_i  = 2'b00;
    rd(5'd9, 3'd0);
    step();
    sb_push("rr_cnt0",   32'h0);         sb_check(data_o);
    step();
    sb_push("rr_cnt1",   32'h1);         sb_check(data_o);
    rd(5'd15, 3'd1);
    sb_push("rr_ebase",  32'hBFC0_0000); sb_check(data_o);

    if (sb.size() != 0) begin
      checks++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
